// File: rtl/router_sched_if.sv
// Requester-side handshake, credit returns and router datapath bundle for router_sched.
// The master modport is the requester/router side; the scheduler takes the slave modport.
interface router_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]              req_valid;
  logic [7:0]              req_addr;
  logic [4*DATA_WIDTH-1:0] req_data;
  logic [3:0]              req_ready;
  logic [3:0]              dst_credit_ret;
  logic [DATA_WIDTH-1:0]   din;
  logic                    din_en;
  logic [1:0]              addr;

  modport master (
    output req_valid, req_addr, req_data, dst_credit_ret,
    input  req_ready, din, din_en, addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, dst_credit_ret,
    output req_ready, din, din_en, addr
  );
endinterface

// File: rtl/router_sched.sv
// Credit-based round-robin scheduler feeding the 1-to-4 router, with a flush/drain FSM.
// Optional sticky over-return flag on output credit_err when ROUTER_SCHED_CREDIT_ERR_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | arbitration enabled; flush moves to S_DRAIN
// S_DRAIN | grants blocked; when all credits are full pulse flush_done, go S_RUN
module router_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4
) (
  input  logic           clk,
  input  logic           resetn,
  router_sched_if.slave  bus,
  input  logic           flush,
  output logic           flush_done
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
  ,
  output logic           credit_err
`endif
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit     [4];
  logic [CW-1:0] credit_nxt [4];
  logic [1:0]    dst [4];
  logic [3:0]    full_vec;
  logic          all_full;
  logic [3:0]    elig;
  logic [3:0]    grant;
  logic          gnt_any;
  logic [1:0]    gnt_idx;
  logic [1:0]    gnt_dst;
  logic [1:0]    idx;
  logic [1:0]    rr_ptr;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dst[i]      = bus.req_addr[2*i +: 2];
      full_vec[i] = (credit[i] == CMAX);
    end
  end

  assign all_full = &full_vec;

  // Gating with resetn keeps req_ready low while reset is held, even though
  // the reset state itself (RUN, full credits) would otherwise allow grants.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = resetn && bus.req_valid[i] && (state == S_RUN) &&
                (credit[dst[i]] != '0);
    end
  end

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    idx     = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = grant;
  assign gnt_dst       = dst[gnt_idx];

  // A grant and a return to the same destination cancel out; returns at full are dropped.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      credit_nxt[d] = credit[d];
      if (gnt_any && (gnt_dst == 2'(d))) begin
        if (!bus.dst_credit_ret[d]) credit_nxt[d] = credit[d] - CW'(1);
      end else if (bus.dst_credit_ret[d] && !full_vec[d]) begin
        credit_nxt[d] = credit[d] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 4; d++) credit[d] <= CMAX;
    end else begin
      for (int d = 0; d < 4; d++) credit[d] <= credit_nxt[d];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      S_RUN: begin
        if (flush) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (all_full) begin
          flush_done = 1'b1;
          state_nxt  = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.din    <= '0;
      bus.addr   <= '0;
      bus.din_en <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      bus.din_en <= gnt_any;
      if (gnt_any) begin
        bus.din  <= bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.addr <= gnt_dst;
        rr_ptr   <= gnt_idx + 2'd1;
      end
    end
  end

`ifdef ROUTER_SCHED_CREDIT_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            credit_err <= 1'b0;
    else if (|(bus.dst_credit_ret & full_vec)) credit_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_router_sched.sv
// Directed self-checking bench for router_sched (CREDITS=4, DATA_WIDTH=32).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later or after the rising edge.
module tb_router_sched;
  localparam int DW = 32;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic flush  = 1'b0;
  logic flush_done;
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
  logic credit_err;
`endif

  int errors = 0;
  int checks = 0;

  router_sched_if #(.DATA_WIDTH(DW)) bus ();

  router_sched #(.DATA_WIDTH(DW), .CREDITS(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
    ,
    .credit_err (credit_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn             = 1'b0;
    bus.req_valid      = '0;
    bus.dst_credit_ret = '0;
    flush              = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid      = 4'hF;
    bus.req_addr       = 8'hE4;
    bus.dst_credit_ret = '0;
    for (int i = 0; i < 4; i++) bus.req_data[i*DW +: DW] = 32'hCAFE_0000 + i;

    // reset held with all requests pending
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_din_en", bus.din_en, 1'b0);
    check("rst_din", bus.din, 32'h0);
    check("rst_addr", bus.addr, 2'd0);
    check("rst_flush_done", flush_done, 1'b0);
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
    check("rst_credit_err", credit_err, 1'b0);
`endif
    resetn = 1'b1; #1;
    check("rst_first_grant", bus.req_ready, 4'b0001);

    // round robin, requester i -> destination i
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      check("rr_ready", bus.req_ready, 4'b0001 << (k % 4));
      @(posedge clk); #1;
      check("rr_din_en", bus.din_en, 1'b1);
      check("rr_addr", bus.addr, k % 4);
      check("rr_din", bus.din, 32'hCAFE_0000 + (k % 4));
    end

    // credit exhaustion: requester 2 -> destination 1
    apply_reset();
    bus.req_valid = 4'b0100;
    bus.req_addr  = 8'h10;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("exh_ready", bus.req_ready, 4'b0100);
      @(posedge clk); #1;
      check("exh_addr", bus.addr, 2'd1);
    end
    @(negedge clk); #1;
    check("exh_block", bus.req_ready, 4'b0000);
    @(posedge clk); #1;
    check("exh_idle", bus.din_en, 1'b0);
    check("exh_hold_addr", bus.addr, 2'd1);
    check("exh_hold_din", bus.din, 32'hCAFE_0002);

    // destination 1 empty must not stall requester 0 on destination 0
    @(negedge clk);
    bus.req_valid = 4'b0101; #1;
    check("skip_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    check("skip_addr", bus.addr, 2'd0);
    check("skip_din", bus.din, 32'hCAFE_0000);

    @(negedge clk);
    bus.req_valid      = 4'b0100;
    bus.dst_credit_ret = 4'b0010; #1;
    check("ret_same_cycle", bus.req_ready, 4'b0000);
    @(negedge clk);
    bus.dst_credit_ret = '0; #1;
    check("ret_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    check("ret_din_en", bus.din_en, 1'b1);
    check("ret_addr", bus.addr, 2'd1);
    @(negedge clk); #1;
    check("ret_one_only", bus.req_ready, 4'b0000);

    // simultaneous grant and return on destination 3
    apply_reset();
    bus.req_valid = 4'b1000;
    bus.req_addr  = 8'hC0; #1;
    check("sim_first", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.dst_credit_ret = 4'b1000; #1;
    check("sim_ready", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.dst_credit_ret = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("sim_left", bus.req_ready, (k < 3) ? 4'b1000 : 4'b0000);
    end

    // refill to full, then one excess return
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dst_credit_ret = 4'b1000;
    end
    @(negedge clk);
    bus.dst_credit_ret = '0; #1;
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
    check("err_clean", credit_err, 1'b0);
`endif
    @(negedge clk);
    bus.dst_credit_ret = 4'b1000;
    @(negedge clk);
    bus.dst_credit_ret = '0; #1;
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
    check("err_set", credit_err, 1'b1);
`endif
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("sat_count", bus.req_ready, (k < 4) ? 4'b1000 : 4'b0000);
    end
`ifdef ROUTER_SCHED_CREDIT_ERR_EN
    check("err_sticky", credit_err, 1'b1);
`endif

    // flush with 3 credits outstanding on destination 0
    apply_reset();
    bus.req_valid = 4'b0001;
    bus.req_addr  = 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) flush = 1'b1;
      #1;
      check("fl_pre_grant", bus.req_ready, 4'b0001);
    end
    for (int c = 3; c < 8; c++) begin
      @(negedge clk);
      bus.dst_credit_ret = (c % 2 == 1) ? 4'b0001 : 4'b0000;
      flush              = (c == 4);
      #1;
      check("fl_no_grant", bus.req_ready, 4'b0000);
      check("fl_done_low", flush_done, 1'b0);
      if (c == 3) check("fl_last_word", bus.din_en, 1'b1);
      if (c == 4) check("fl_idle", bus.din_en, 1'b0);
    end
    @(negedge clk);
    bus.dst_credit_ret = '0;
    flush              = 1'b0; #1;
    check("fl_done_pulse", flush_done, 1'b1);
    check("fl_done_no_grant", bus.req_ready, 4'b0000);
    @(negedge clk); #1;
    check("fl_done_once", flush_done, 1'b0);
    check("fl_resume", bus.req_ready, 4'b0001);

    // flush with credits already full finishes after one DRAIN cycle
    apply_reset();
    flush = 1'b1; #1;
    check("ff_run", flush_done, 1'b0);
    @(negedge clk);
    flush = 1'b0; #1;
    check("ff_done", flush_done, 1'b1);
    @(negedge clk);
    bus.req_valid = 4'b0001; #1;
    check("ff_done_once", flush_done, 1'b0);
    check("ff_resume", bus.req_ready, 4'b0001);

    // reset in DRAIN with credits outstanding
    @(negedge clk); #1;
    check("mr_grant2", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    flush         = 1'b1;
    @(negedge clk);
    flush         = 1'b0;
    bus.req_valid = 4'b0001; #1;
    check("mr_drain_block", bus.req_ready, 4'b0000);
    check("mr_drain_done", flush_done, 1'b0);
    @(negedge clk);
    resetn = 1'b0; #1;
    check("mr_rst_ready", bus.req_ready, 4'b0000);
    check("mr_rst_din_en", bus.din_en, 1'b0);
    check("mr_rst_din", bus.din, 32'h0);
    check("mr_rst_done", flush_done, 1'b0);
    @(negedge clk);
    resetn = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("mr_full_credits", bus.req_ready, (k < 4) ? 4'b0001 : 4'b0000);
      check("mr_no_done", flush_done, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
